// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types, default timeouts and round-robin pick helper for the tx arbiter
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    localparam int DEFAULT_START_TIMEOUT = 16;
    localparam int DEFAULT_LOCK_TIMEOUT  = 65535;
    localparam int MAX_REQUESTERS        = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of valid searching ptr, ptr+1, ... modulo n; ptr must be below n.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQUESTERS-1:0] valid,
        input logic [2:0]                ptr,
        input int                        n
    );
        rr_pick_t   res;
        logic [3:0] cand;
        res = '0;
        for (int k = 0; k < MAX_REQUESTERS; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= 4'(n)) begin
                cand = cand - 4'(n);
            end
            if (k < n && !res.found && valid[cand[2:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester, transmitter and status signals of the uart tx arbiter
interface uart_tx_arbiter_if #(
    parameter int REQUESTERS = 4,
    parameter int DATA_WIDTH = 8
);
    logic [REQUESTERS-1:0]            reqValid;
    logic [REQUESTERS*DATA_WIDTH-1:0] reqData;
    logic [REQUESTERS-1:0]            reqLast;
    logic [REQUESTERS-1:0]            reqReady;
    logic                             txStart;
    logic [DATA_WIDTH-1:0]            byteForTx;
    logic                             txReady;
    logic [REQUESTERS-1:0]            grant;
    logic                             busy;
    logic                             startErr;
    logic                             lockDrop;

    modport slave (
        input  reqValid, reqData, reqLast, txReady,
        output reqReady, txStart, byteForTx, grant, busy, startErr, lockDrop
    );

    modport master (
        output reqValid, reqData, reqLast, txReady,
        input  reqReady, txStart, byteForTx, grant, busy, startErr, lockDrop
    );
endinterface

// File: rtl/uart_rr_picker.sv
// rtl/uart_rr_picker.sv - combinational round-robin winner search over a valid vector
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int REQUESTERS   = 4,
    parameter int REQ_ID_WIDTH = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0]   valid,
    input  logic [REQ_ID_WIDTH-1:0] ptr,
    output logic [REQ_ID_WIDTH-1:0] winner,
    output logic                    found
);
    logic [MAX_REQUESTERS-1:0] valid_ext;
    logic [2:0]                ptr_ext;
    rr_pick_t                  pick;

    always_comb begin
        valid_ext                   = '0;
        valid_ext[REQUESTERS-1:0]   = valid;
        ptr_ext                     = 3'(ptr);
        pick                        = rr_pick(valid_ext, ptr_ext, REQUESTERS);
        found                       = pick.found;
        winner                      = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (pick.idx == 3'(i)) begin
                winner = REQ_ID_WIDTH'(i);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart transmitter, with burst lock and watchdogs
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int REQUESTERS    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int REQ_ID_WIDTH  = $clog2(REQUESTERS),
    parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT,
    parameter int LOCK_TIMEOUT  = DEFAULT_LOCK_TIMEOUT
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int CNT_MAX   = (START_TIMEOUT > LOCK_TIMEOUT) ? START_TIMEOUT : LOCK_TIMEOUT;
    localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

    typedef logic [REQ_ID_WIDTH-1:0] req_id_t;
    typedef logic [CNT_WIDTH-1:0]    cnt_t;

    localparam cnt_t    START_LAST = cnt_t'(START_TIMEOUT - 1);
    localparam cnt_t    LOCK_LAST  = cnt_t'(LOCK_TIMEOUT - 1);
    localparam req_id_t LAST_ID    = req_id_t'(REQUESTERS - 1);

    arb_state_t            state_q, state_d;
    logic                  lock_q, lock_d;
    req_id_t               rr_ptr_q, rr_ptr_d;
    req_id_t               owner_q, owner_d;
    cnt_t                  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] byte_q, byte_d;
    logic                  tx_start_q, tx_start_d;
    logic [REQUESTERS-1:0] req_ready_q, req_ready_d;
    logic [REQUESTERS-1:0] grant_q, grant_d;
    logic                  start_err_q, start_err_d;
    logic                  lock_drop_q, lock_drop_d;

    req_id_t pick_winner;
    logic    pick_found;
    req_id_t win;
    logic    owner_valid;
    logic    accept;

    function automatic req_id_t next_id(input req_id_t id);
        return (id == LAST_ID) ? '0 : id + req_id_t'(1);
    endfunction

    uart_rr_picker #(
        .REQUESTERS   (REQUESTERS),
        .REQ_ID_WIDTH (REQ_ID_WIDTH)
    ) u_picker (
        .valid  (bus.reqValid),
        .ptr    (rr_ptr_q),
        .winner (pick_winner),
        .found  (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        tx_start_d  = 1'b0;
        req_ready_d = '0;
        grant_d     = grant_q;
        start_err_d = 1'b0;
        lock_drop_d = 1'b0;

        // While a burst is locked only its owner may be served.
        owner_valid = bus.reqValid[owner_q];
        win         = lock_q ? owner_q : pick_winner;
        accept      = (state_q == IDLE) && bus.txReady && (lock_q ? owner_valid : pick_found);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d          = win;
                    byte_d           = bus.reqData[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                    tx_start_d       = 1'b1;
                    req_ready_d[win] = 1'b1;
                    grant_d          = '0;
                    grant_d[win]     = 1'b1;
                    lock_d           = ~bus.reqLast[win];
                    cnt_d            = '0;
                    state_d          = WAIT_BUSY;
                end else if (lock_q && !owner_valid) begin
                    if (cnt_q == LOCK_LAST) begin
                        lock_drop_d = 1'b1;
                        lock_d      = 1'b0;
                        rr_ptr_d    = next_id(owner_q);
                        cnt_d       = '0;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_BUSY: begin
                if (!bus.txReady) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == START_LAST) begin
                    start_err_d = 1'b1;
                    lock_d      = 1'b0;
                    rr_ptr_d    = next_id(owner_q);
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            WAIT_DONE: begin
                if (bus.txReady) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!lock_q) begin
                        rr_ptr_d = next_id(owner_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lock_q      <= 1'b0;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            byte_q      <= '0;
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            grant_q     <= '0;
            start_err_q <= 1'b0;
            lock_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            tx_start_q  <= tx_start_d;
            req_ready_q <= req_ready_d;
            grant_q     <= grant_d;
            start_err_q <= start_err_d;
            lock_drop_q <= lock_drop_d;
        end
    end

    assign bus.reqReady  = req_ready_q;
    assign bus.txStart   = tx_start_q;
    assign bus.byteForTx = byte_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q != IDLE) || lock_q;
    assign bus.startErr  = start_err_q;
    assign bus.lockDrop  = lock_drop_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    uart_tx_arbiter_if #(.REQUESTERS(N), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(
        .REQUESTERS    (N),
        .DATA_WIDTH    (DW),
        .REQ_ID_WIDTH  (2),
        .START_TIMEOUT (16),
        .LOCK_TIMEOUT  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [8:0] src_mem [N][16];
    int         src_len [N];
    int         src_head[N];
    int         tx_busy = 10;
    bit         tx_stuck = 1'b0;
    int         tx_left = 0;
    int         order_q[$];
    logic [7:0] data_q[$];
    int         start_err_cnt = 0;
    int         lock_drop_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [7:0] d, input logic l);
        src_mem[i][src_len[i]] = {l, d};
        src_len[i]++;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            src_len[i]  = 0;
            src_head[i] = 0;
        end
    endtask

    task automatic clear_logs();
        order_q.delete();
        data_q.delete();
        start_err_cnt = 0;
        lock_drop_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_sources();
        tx_stuck = 1'b0;
        tick();
        tick();
        clear_logs();
        rst = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!bus.txStart && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_start_seen"}, 32'(bus.txStart), 1);
    endtask

    task automatic wait_quiet(input string tag);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 400) begin
            done = !bus.busy && bus.txReady && !bus.txStart;
            for (int i = 0; i < N; i++) begin
                if (src_head[i] < src_len[i]) done = 1'b0;
            end
            if (!done) begin
                tick();
                n++;
            end
        end
        check({tag, "_quiet"}, 32'(done), 1);
    endtask

    task automatic check_log(input string tag, input int n, input int eo[8], input logic [7:0] ed[8]);
        check({tag, "_len"}, 32'(order_q.size()), 32'(n));
        for (int k = 0; k < n && k < order_q.size(); k++) begin
            check($sformatf("%s_who%0d", tag, k), 32'(order_q[k]), 32'(eo[k]));
            check($sformatf("%s_byte%0d", tag, k), 32'(data_q[k]), 32'(ed[k]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_reqReady"},  32'(bus.reqReady),  0);
        check({tag, "_txStart"},   32'(bus.txStart),   0);
        check({tag, "_byteForTx"}, 32'(bus.byteForTx), 0);
        check({tag, "_grant"},     32'(bus.grant),     0);
        check({tag, "_busy"},      32'(bus.busy),      0);
        check({tag, "_startErr"},  32'(bus.startErr),  0);
        check({tag, "_lockDrop"},  32'(bus.lockDrop),  0);
    endtask

    // Requester model: present the head byte, pop it when reqReady is seen.
    initial begin
        bus.reqValid = '0;
        bus.reqData  = '0;
        bus.reqLast  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (bus.reqReady[i] && src_head[i] < src_len[i]) src_head[i]++;
                if (src_head[i] < src_len[i]) begin
                    bus.reqValid[i]          = 1'b1;
                    bus.reqData[i*DW +: DW]  = src_mem[i][src_head[i]][7:0];
                    bus.reqLast[i]           = src_mem[i][src_head[i]][8];
                end else begin
                    bus.reqValid[i]          = 1'b0;
                    bus.reqData[i*DW +: DW]  = '0;
                    bus.reqLast[i]           = 1'b0;
                end
            end
        end
    end

    // Transmitter model: tx_ready low for tx_busy cycles after each start pulse.
    initial begin
        bus.txReady = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.txReady = 1'b1;
                tx_left     = 0;
            end else if (tx_left > 0) begin
                tx_left--;
                if (tx_left == 0) bus.txReady = 1'b1;
            end else if (bus.txStart && !tx_stuck) begin
                bus.txReady = 1'b0;
                tx_left     = tx_busy;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.txStart) begin
                    for (int i = 0; i < N; i++) begin
                        if (bus.reqReady[i]) order_q.push_back(i);
                    end
                    data_q.push_back(bus.byteForTx);
                end
                if (bus.startErr) start_err_cnt++;
                if (bus.lockDrop) lock_drop_cnt++;
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        clear_sources();
        tick();
        tick();
        check_reset_outputs("rst");
        clear_logs();
        rst = 1'b0;

        // single requester, one-cycle latency
        load(1, 8'hA5, 1'b1);
        n = 0;
        while (!bus.reqValid[1] && n < 5) begin
            tick();
            n++;
        end
        tick();
        check("t1_txStart",  32'(bus.txStart),   1);
        check("t1_reqReady", 32'(bus.reqReady),  'h2);
        check("t1_byte",     32'(bus.byteForTx), 'hA5);
        check("t1_grant",    32'(bus.grant),     'h2);
        check("t1_busy",     32'(bus.busy),      1);
        tick();
        check("t1_txStart_pulse",  32'(bus.txStart),  0);
        check("t1_reqReady_pulse", 32'(bus.reqReady), 0);
        check("t1_grant_hold",     32'(bus.grant),    'h2);
        wait_quiet("t1");

        // all four valid: order 0,1,2,3 then wrap to 0
        do_reset();
        load(0, 8'h10, 1'b1);
        load(0, 8'h20, 1'b1);
        load(1, 8'h11, 1'b1);
        load(2, 8'h12, 1'b1);
        load(3, 8'h13, 1'b1);
        wait_quiet("t2");
        check_log("t2", 5, '{0, 1, 2, 3, 0, 0, 0, 0},
                  '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h00, 8'h00, 8'h00});
        check("t2_no_start_err", 32'(start_err_cnt), 0);

        // locked burst from req0 while req2 waits
        do_reset();
        load(0, 8'hB0, 1'b0);
        load(0, 8'hB1, 1'b0);
        load(0, 8'hB2, 1'b1);
        load(2, 8'hC2, 1'b1);
        wait_quiet("t3");
        check_log("t3", 4, '{0, 0, 0, 2, 0, 0, 0, 0},
                  '{8'hB0, 8'hB1, 8'hB2, 8'hC2, 8'h00, 8'h00, 8'h00, 8'h00});

        // txReady never falls: startErr 16 cycles after WAIT_BUSY entry
        do_reset();
        tx_stuck = 1'b1;
        load(1, 8'h5A, 1'b0);
        wait_start("t4");
        n = 0;
        while (!bus.startErr && n < 40) begin
            tick();
            n++;
        end
        check("t4_err_offset", 32'(n),         16);
        check("t4_busy",       32'(bus.busy),  0);
        check("t4_grant",      32'(bus.grant), 'h2);
        tick();
        check("t4_err_pulse",  32'(bus.startErr), 0);
        tx_stuck = 1'b0;
        wait_quiet("t4");
        check("t4_err_count",  32'(start_err_cnt), 1);

        // locked owner goes quiet: lockDrop then waiting req3 is served
        do_reset();
        load(1, 8'h71, 1'b0);
        load(3, 8'h73, 1'b1);
        wait_start("t5");
        check("t5_first_owner", 32'(bus.reqReady), 'h2);
        n = 0;
        while (!bus.lockDrop && n < 60) begin
            tick();
            n++;
        end
        check("t5_drop_offset", 32'(n),         19);
        check("t5_drop_grant",  32'(bus.grant), 'h2);
        check("t5_drop_busy",   32'(bus.busy),  0);
        tick();
        check("t5_next_start",  32'(bus.txStart),   1);
        check("t5_next_ready",  32'(bus.reqReady),  'h8);
        check("t5_next_grant",  32'(bus.grant),     'h8);
        check("t5_next_byte",   32'(bus.byteForTx), 'h73);
        wait_quiet("t5");
        check("t5_drop_count",  32'(lock_drop_cnt), 1);

        // reset in WAIT_DONE, then first grant goes to req0
        do_reset();
        load(2, 8'h62, 1'b1);
        wait_start("t6");
        tick();
        tick();
        tick();
        check("t6_mid_busy",    32'(bus.busy),    1);
        check("t6_mid_txReady", 32'(bus.txReady), 0);
        rst = 1'b1;
        clear_sources();
        tick();
        check_reset_outputs("t6_rst");
        load(2, 8'h26, 1'b1);
        load(0, 8'h06, 1'b1);
        clear_logs();
        rst = 1'b0;
        wait_start("t6b");
        check("t6_first_ready", 32'(bus.reqReady),  'h1);
        check("t6_first_grant", 32'(bus.grant),     'h1);
        check("t6_first_byte",  32'(bus.byteForTx), 'h06);
        wait_quiet("t6");
        check_log("t6", 2, '{0, 2, 0, 0, 0, 0, 0, 0},
                  '{8'h06, 8'h26, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
